// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for the multi-port byte-serial memory arbiter:
// size encodings, IO-region test, FSM encoding and byte-count helper.
package mem_port_arb_pkg;

  localparam logic [1:0] SIZE_1B   = 2'd0;
  localparam logic [1:0] SIZE_2B   = 2'd1;
  localparam logic [1:0] SIZE_4B   = 2'd2;
  localparam logic [1:0] IO_REGION = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_IO_WAIT
  } state_e;

  // Size code 3 is not a legal request size; it behaves as a word access.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SIZE_1B: return 3'd1;
      SIZE_2B: return 3'd2;
      SIZE_4B: return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_io(input logic [1:0] addr_17_16);
    return addr_17_16 == IO_REGION;
  endfunction

endpackage

// File: rtl/mem_port_arb_port_arbiter.sv
// Picks one requester: lowest index in fixed mode, or the first requester
// at or after the pointer in round-robin mode.
module port_arbiter
  import mem_port_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ARB_RR    = 0,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 valid_o
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (ARB_RR != 0) begin
        cand = IDX_W'((int'(ptr_i) + i) % NUM_PORTS);
      end else begin
        cand = IDX_W'(i);
      end
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// Arbitrates NUM_PORTS 1/2/4-byte little-endian requesters onto one
// byte-serial RAM/IO bus, with per-port read flush and IO back-pressure.
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ARB_RR    = 0,
  parameter int ADDR_W    = 32
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic [NUM_PORTS-1:0]        req_in,
  input  logic [NUM_PORTS-1:0]        we_in,
  input  logic [2*NUM_PORTS-1:0]      size_in,
  input  logic [ADDR_W*NUM_PORTS-1:0] addr_in,
  input  logic [32*NUM_PORTS-1:0]     wdata_in,
  input  logic [NUM_PORTS-1:0]        flush_in,
  output logic [NUM_PORTS-1:0]        done_out,
  output logic [31:0]                 rdata_out,
  output logic                        busy_out,
  input  logic [7:0]                  mem_din,
  output logic [7:0]                  mem_dout,
  output logic [ADDR_W-1:0]           mem_a,
  output logic                        mem_wr,
  input  logic                        io_buffer_full
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [1:0]        size_a  [NUM_PORTS];
  logic [ADDR_W-1:0] addr_a  [NUM_PORTS];
  logic [31:0]       wdata_a [NUM_PORTS];

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign size_a[gi]  = size_in[2*gi +: 2];
    assign addr_a[gi]  = addr_in[ADDR_W*gi +: ADDR_W];
    assign wdata_a[gi] = wdata_in[32*gi +: 32];
  end

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     port_q, port_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [2:0]           nbytes_q, nbytes_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [31:0]          rbuf_q, rbuf_d;
  logic [NUM_PORTS-1:0] done_q, done_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [ADDR_W-1:0]    mem_a_q, mem_a_d;
  logic [7:0]           mem_dout_q, mem_dout_d;
  logic                 mem_wr_q, mem_wr_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;

  logic [NUM_PORTS-1:0] grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_valid;
  logic                 start_wr;

  // The port that just finished is masked so a still-high req is not regranted.
  port_arbiter #(
    .NUM_PORTS(NUM_PORTS),
    .ARB_RR   (ARB_RR),
    .IDX_W    (IDX_W)
  ) u_arb (
    .req_i  (req_in & ~done_q & ~flush_in),
    .ptr_i  (ptr_q),
    .grant_o(grant),
    .idx_o  (grant_idx),
    .valid_o(grant_valid)
  );

  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    nbytes_d   = nbytes_q;
    cnt_d      = cnt_q;
    rbuf_d     = rbuf_q;
    done_d     = '0;
    rdata_d    = rdata_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    ptr_d      = ptr_q;
    start_wr   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mem_wr_d = 1'b0;
        if (grant_valid) begin
          port_d   = grant_idx;
          addr_d   = addr_a[grant_idx];
          wdata_d  = wdata_a[grant_idx];
          nbytes_d = byte_count(size_a[grant_idx]);
          cnt_d    = 3'd0;
          rbuf_d   = '0;
          if (ARB_RR != 0) begin
            ptr_d = (grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx + IDX_W'(1);
          end
          if (!(|(grant & we_in))) begin
            mem_a_d = addr_a[grant_idx];
            state_d = ST_READ;
          end else if (is_io(addr_a[grant_idx][17:16]) && io_buffer_full) begin
            state_d = ST_IO_WAIT;
          end else begin
            start_wr = 1'b1;
          end
        end
      end
      ST_READ: begin
        mem_wr_d = 1'b0;
        if (flush_in[port_q]) begin
          state_d = ST_IDLE;
        end else begin
          rbuf_d[{cnt_q[1:0], 3'b000} +: 8] = mem_din;
          if (cnt_q + 3'd1 == nbytes_q) begin
            done_d[port_q] = 1'b1;
            rdata_d        = rbuf_d;
            state_d        = ST_IDLE;
          end else begin
            cnt_d   = cnt_q + 3'd1;
            mem_a_d = addr_q + ADDR_W'(cnt_q + 3'd1);
          end
        end
      end
      ST_WRITE: begin
        mem_a_d    = addr_q + ADDR_W'(cnt_q);
        mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        mem_wr_d   = 1'b1;
        if (cnt_q + 3'd1 == nbytes_q) begin
          done_d[port_q] = 1'b1;
          state_d        = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_IO_WAIT: begin
        mem_wr_d = 1'b0;
        if (flush_in[port_q]) begin
          state_d = ST_IDLE;
        end else if (!io_buffer_full) begin
          start_wr = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // First byte of a write; a single-byte write completes on this edge.
    if (start_wr) begin
      mem_a_d    = addr_d;
      mem_dout_d = wdata_d[7:0];
      mem_wr_d   = 1'b1;
      if (nbytes_d == 3'd1) begin
        done_d[port_d] = 1'b1;
        state_d        = ST_IDLE;
      end else begin
        cnt_d   = 3'd1;
        state_d = ST_WRITE;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      port_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      nbytes_q   <= '0;
      cnt_q      <= '0;
      rbuf_q     <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      ptr_q      <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      port_q     <= port_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      nbytes_q   <= nbytes_d;
      cnt_q      <= cnt_d;
      rbuf_q     <= rbuf_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      ptr_q      <= ptr_d;
    end
  end

  assign done_out  = done_q;
  assign rdata_out = rdata_q;
  assign busy_out  = (state_q != ST_IDLE);
  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign mem_wr    = mem_wr_q & rdy_in;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench: a fixed-priority and a round-robin instance share stimulus;
// a small combinational RAM answers reads for both.
module tb_mem_port_arb;

  logic        clk = 1'b0;
  logic        rst, rdy, io_full;
  logic [1:0]  req, we, flush;
  logic [3:0]  size;
  logic [63:0] addr, wdata;
  logic [1:0]  done, done_rr;
  logic [31:0] rdata, rdata_rr;
  logic        busy, busy_rr, mem_wr, mem_wr_rr;
  logic [7:0]  mem_din, mem_din_rr, mem_dout, mem_dout_rr;
  logic [31:0] mem_a, mem_a_rr;
  logic [7:0]  ram [16];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign mem_din    = ram[mem_a[3:0]];
  assign mem_din_rr = ram[mem_a_rr[3:0]];

  mem_port_arb #(.NUM_PORTS(2), .ARB_RR(0), .ADDR_W(32)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .req_in(req), .we_in(we),
    .size_in(size), .addr_in(addr), .wdata_in(wdata), .flush_in(flush),
    .done_out(done), .rdata_out(rdata), .busy_out(busy), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_full)
  );

  mem_port_arb #(.NUM_PORTS(2), .ARB_RR(1), .ADDR_W(32)) dut_rr (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .req_in(req), .we_in(we),
    .size_in(size), .addr_in(addr), .wdata_in(wdata), .flush_in(flush),
    .done_out(done_rr), .rdata_out(rdata_rr), .busy_out(busy_rr), .mem_din(mem_din_rr),
    .mem_dout(mem_dout_rr), .mem_a(mem_a_rr), .mem_wr(mem_wr_rr), .io_buffer_full(io_full)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic w, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
    req[p]          = 1'b1;
    we[p]           = w;
    size[2*p +: 2]  = sz;
    addr[32*p +: 32]  = a;
    wdata[32*p +: 32] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; io_full = 1'b0; req = '0; we = '0; flush = '0;
    size = '0; addr = '0; wdata = '0;
    step(); step();
    tests_run++;
    if (done !== 2'b00 || rdata !== 32'h0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_status: done=%b rdata=%h busy=%b, want 00/0/0", done, rdata, busy);
    end
    tests_run++;
    if (mem_a !== 32'h0 || mem_dout !== 8'h0 || mem_wr !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_bus: a=%h dout=%h wr=%b, want 0/0/0", mem_a, mem_dout, mem_wr);
    end
    tests_run++;
    if (done_rr !== 2'b00 || busy_rr !== 1'b0 || mem_wr_rr !== 1'b0 || mem_dout_rr !== 8'h0) begin
      tests_failed++;
      $display("FAIL reset_rr: done=%b busy=%b wr=%b dout=%h, want all 0",
               done_rr, busy_rr, mem_wr_rr, mem_dout_rr);
    end
    rst = 1'b0;
    $display("[TB] reset released");
  endtask

  task automatic test_read4();
    set_port(1, 1'b0, 2'd2, 32'h1000, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      tests_run++;
      if (mem_a !== 32'h1000 + k || done !== 2'b00 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL read4_addr%0d: a=%h done=%b busy=%b, want %h/00/1",
                 k, mem_a, done, busy, 32'h1000 + k);
      end
    end
    step();
    tests_run++;
    if (done !== 2'b10 || rdata !== 32'h00112233 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL read4_done: done=%b rdata=%h busy=%b, want 10/00112233/0", done, rdata, busy);
    end
    $display("[TB] read4 port1 @1000 rdata=%h", rdata);
    req = '0;
    step();
    tests_run++;
    if (done !== 2'b00) begin
      tests_failed++;
      $display("FAIL read4_pulse: done=%b, want 00", done);
    end
  endtask

  task automatic test_back_to_back();
    set_port(0, 1'b1, 2'd1, 32'h20, 32'h0000BEEF);
    set_port(1, 1'b1, 2'd0, 32'h40, 32'h00000077);
    step();
    tests_run++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h20 || mem_dout !== 8'hEF || done !== 2'b00) begin
      tests_failed++;
      $display("FAIL wr2_byte0: wr=%b a=%h dout=%h done=%b, want 1/20/EF/00", mem_wr, mem_a, mem_dout, done);
    end
    step();
    tests_run++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h21 || mem_dout !== 8'hBE || done !== 2'b01) begin
      tests_failed++;
      $display("FAIL wr2_byte1: wr=%b a=%h dout=%h done=%b, want 1/21/BE/01", mem_wr, mem_a, mem_dout, done);
    end
    $display("[TB] write2 port0 @20 data=BEEF");
    req[0] = 1'b0;
    step();
    tests_run++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h40 || mem_dout !== 8'h77 || done !== 2'b10) begin
      tests_failed++;
      $display("FAIL b2b_next: wr=%b a=%h dout=%h done=%b, want 1/40/77/10", mem_wr, mem_a, mem_dout, done);
    end
    $display("[TB] write1 port1 @40 data=77");
    req[1] = 1'b0;
    step();
    tests_run++;
    if (mem_wr !== 1'b0 || done !== 2'b00 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_idle: wr=%b done=%b busy=%b, want 0/00/0", mem_wr, done, busy);
    end
  endtask

  task automatic test_arbitration();
    logic [1:0]  exp_rr;
    logic [31:0] exp_rd_rr;
    rst = 1'b1; step(); rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      set_port(0, 1'b0, 2'd0, 32'h1000, 32'h0);
      set_port(1, 1'b0, 2'd0, 32'h1001, 32'h0);
      step(); step();
      exp_rr    = (r % 2 == 0) ? 2'b01 : 2'b10;
      exp_rd_rr = (r % 2 == 0) ? 32'h33 : 32'h22;
      tests_run++;
      if (done !== 2'b01 || rdata !== 32'h33) begin
        tests_failed++;
        $display("FAIL fixed_round%0d: done=%b rdata=%h, want 01/33", r, done, rdata);
      end
      tests_run++;
      if (done_rr !== exp_rr || rdata_rr !== exp_rd_rr) begin
        tests_failed++;
        $display("FAIL rr_round%0d: done=%b rdata=%h, want %b/%h", r, done_rr, rdata_rr, exp_rr, exp_rd_rr);
      end
      $display("[TB] contest %0d fixed=%b rr=%b", r, done, done_rr);
      req = '0;
      step();
    end
  endtask

  task automatic test_io_wait();
    io_full = 1'b1;
    set_port(0, 1'b1, 2'd0, 32'h00030000, 32'h41);
    for (int c = 0; c < 3; c++) begin
      step();
      tests_run++;
      if (mem_wr !== 1'b0 || done !== 2'b00 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL io_hold%0d: wr=%b done=%b busy=%b, want 0/00/1", c, mem_wr, done, busy);
      end
    end
    io_full = 1'b0;
    step();
    tests_run++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h00030000 || mem_dout !== 8'h41 || done !== 2'b01) begin
      tests_failed++;
      $display("FAIL io_issue: wr=%b a=%h dout=%h done=%b, want 1/30000/41/01", mem_wr, mem_a, mem_dout, done);
    end
    $display("[TB] io write port0 @30000 data=41");
    req = '0;
    step();
    tests_run++;
    if (mem_wr !== 1'b0 || done !== 2'b00) begin
      tests_failed++;
      $display("FAIL io_single: wr=%b done=%b, want 0/00", mem_wr, done);
    end
  endtask

  task automatic test_flush();
    set_port(1, 1'b0, 2'd2, 32'h1000, 32'h0);
    step();
    set_port(0, 1'b0, 2'd0, 32'h1004, 32'h0);
    step(); step();
    flush[1] = 1'b1;
    step();
    tests_run++;
    if (busy !== 1'b0 || done !== 2'b00 || mem_wr !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_idle: busy=%b done=%b wr=%b, want 0/00/0", busy, done, mem_wr);
    end
    flush[1] = 1'b0; req[1] = 1'b0;
    step();
    tests_run++;
    if (busy !== 1'b1 || mem_a !== 32'h1004 || done !== 2'b00) begin
      tests_failed++;
      $display("FAIL flush_regrant: busy=%b a=%h done=%b, want 1/1004/00", busy, mem_a, done);
    end
    step();
    tests_run++;
    if (done !== 2'b01 || rdata !== 32'h5C) begin
      tests_failed++;
      $display("FAIL flush_next_done: done=%b rdata=%h, want 01/5C", done, rdata);
    end
    $display("[TB] flushed port1 read, port0 read rdata=%h", rdata);
    req = '0;
    step();
  endtask

  task automatic test_rdy_stall();
    set_port(0, 1'b0, 2'd2, 32'h1000, 32'h0);
    step(); step();
    rdy = 1'b0;
    step(); step();
    tests_run++;
    if (mem_a !== 32'h1001 || done !== 2'b00 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rdy_read_hold: a=%h done=%b busy=%b, want 1001/00/1", mem_a, done, busy);
    end
    rdy = 1'b1;
    step(); step(); step();
    tests_run++;
    if (done !== 2'b01 || rdata !== 32'h00112233) begin
      tests_failed++;
      $display("FAIL rdy_read_done: done=%b rdata=%h, want 01/00112233", done, rdata);
    end
    $display("[TB] stalled read4 port0 rdata=%h", rdata);
    req = '0;
    step();
    set_port(0, 1'b1, 2'd1, 32'h70, 32'h0000BEEF);
    step();
    rdy = 1'b0;
    #1;
    tests_run++;
    if (mem_wr !== 1'b0) begin
      tests_failed++;
      $display("FAIL rdy_wr_gate: wr=%b, want 0", mem_wr);
    end
    step();
    tests_run++;
    if (mem_a !== 32'h70 || mem_wr !== 1'b0 || done !== 2'b00) begin
      tests_failed++;
      $display("FAIL rdy_wr_hold: a=%h wr=%b done=%b, want 70/0/00", mem_a, mem_wr, done);
    end
    rdy = 1'b1;
    step();
    tests_run++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h71 || mem_dout !== 8'hBE || done !== 2'b01) begin
      tests_failed++;
      $display("FAIL rdy_wr_resume: wr=%b a=%h dout=%h done=%b, want 1/71/BE/01", mem_wr, mem_a, mem_dout, done);
    end
    $display("[TB] stalled write2 port0 @70");
    req = '0;
    step();
  endtask

  task automatic test_reset_mid_write();
    set_port(0, 1'b1, 2'd2, 32'h60, 32'h11223344);
    step(); step();
    tests_run++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h61 || mem_dout !== 8'h33) begin
      tests_failed++;
      $display("FAIL rstw_byte1: wr=%b a=%h dout=%h, want 1/61/33", mem_wr, mem_a, mem_dout);
    end
    rst = 1'b1; req = '0;
    step();
    tests_run++;
    if (mem_wr !== 1'b0 || mem_a !== 32'h0 || mem_dout !== 8'h0 || done !== 2'b00 ||
        busy !== 1'b0 || rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL rstw_clear: wr=%b a=%h dout=%h done=%b busy=%b rdata=%h, want all 0",
               mem_wr, mem_a, mem_dout, done, busy, rdata);
    end
    rst = 1'b0;
    step();
    tests_run++;
    if (done !== 2'b00 || mem_wr !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstw_nodone: done=%b wr=%b, want 00/0", done, mem_wr);
    end
    $display("[TB] write aborted by reset");
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    ram[0] = 8'h33; ram[1] = 8'h22; ram[2] = 8'h11; ram[3] = 8'h00; ram[4] = 8'h5C;
    test_reset();
    test_read4();
    test_back_to_back();
    test_arbitration();
    test_io_wait();
    test_flush();
    test_rdy_stall();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t, limit 200000", $time);
    $fatal(1, "timeout");
  end

endmodule
